// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle accumulator-free register CPU.
//   Fetch/execute/memory sequencer with a NREGS x DATA_W register file.
//   Ports:
//     CLK, RESET         clock (rising edge) and synchronous active-high reset
//     INSTRUCTION        fetched word {OP, RD/IMM1, RT, RS/IMM2}
//     I_BUSYWAIT         instruction memory not ready (stalls FETCH)
//     PC                 fetch address
//     D_READ, D_WRITE    data memory request strobes (MEM_REQ/MEM_WAIT only)
//     D_ADDRESS          data address
//     D_WRITEDATA        store data
//     D_READDATA         load data
//     D_BUSYWAIT         data memory not ready (sampled in MEM_WAIT only)
//     HALTED             core stopped on an illegal opcode
//     INSTRET            retired-instruction count (wraps)
module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              I_BUSYWAIT,
  output logic [PC_W-1:0]   PC,
  output logic              D_READ,
  output logic              D_WRITE,
  output logic [DATA_W-1:0] D_ADDRESS,
  output logic [DATA_W-1:0] D_WRITEDATA,
  input  logic [DATA_W-1:0] D_READDATA,
  input  logic              D_BUSYWAIT,
  output logic              HALTED,
  output logic [31:0]       INSTRET
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [7:0] DW8 = 8'(DATA_W);

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_MULT  = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;
  localparam logic [7:0] OP_SRA   = 8'd15;
  localparam logic [7:0] OP_ROR   = 8'd16;
  localparam logic [7:0] OP_BNE   = 8'd17;

  typedef enum logic [2:0] {FETCH, EXEC, MEM_REQ, MEM_WAIT, HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       instret_q, instret_d;
  logic              halted_q, halted_d;
  logic              d_read_q, d_read_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic              rf_we;
  logic [IDX_W-1:0]  rf_widx;
  logic [DATA_W-1:0] rf_wdata;

  logic [7:0]        op, imm1, imm2, rot;
  logic [IDX_W-1:0]  rd_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0] rt_val, rs_val, imm2_sext, imm2_zext, alu;
  logic              alu_op, mem_op, is_load, illegal, br_taken;
  logic [PC_W-1:0]   pc_plus4, br_target;
  logic              unused_rt_hi;

  // Field decode of the latched instruction
  always_comb begin
    op        = ir_q[31:24];
    imm1      = ir_q[23:16];
    imm2      = ir_q[7:0];
    rd_idx    = ir_q[16 +: IDX_W];
    rt_idx    = ir_q[8 +: IDX_W];
    rs_idx    = ir_q[0 +: IDX_W];
    rt_val    = rf_q[rt_idx];
    rs_val    = rf_q[rs_idx];
    imm2_sext = DATA_W'($signed(imm2));
    imm2_zext = DATA_W'(imm2);
    rot       = imm2 % DW8;
    pc_plus4  = pc_q + PC_W'(4);
    br_target = pc_plus4 + (PC_W'($signed(imm1)) << 2);
    alu_op    = op inside {OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_MULT, OP_SLL, OP_SRL, OP_SRA, OP_ROR};
    mem_op    = op inside {OP_LWD, OP_LWI, OP_SWD, OP_SWI};
    is_load   = op inside {OP_LWD, OP_LWI};
    illegal   = op > OP_BNE;
    unused_rt_hi = ^ir_q[15:8];
  end

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_J:    br_taken = 1'b1;
      OP_BEQ:  br_taken = (rt_val == rs_val);
      OP_BNE:  br_taken = (rt_val != rs_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Shift amounts are the full 8-bit IMM2; out-of-range amounts are
  // handled explicitly rather than relying on operator semantics.
  always_comb begin
    alu = '0;
    case (op)
      OP_LOADI: alu = imm2_sext;
      OP_MOV:   alu = rs_val;
      OP_ADD:   alu = rt_val + rs_val;
      OP_SUB:   alu = rt_val - rs_val;
      OP_AND:   alu = rt_val & rs_val;
      OP_OR:    alu = rt_val | rs_val;
      OP_MULT:  alu = rt_val * rs_val;
      OP_SLL:   alu = (imm2 >= DW8) ? '0 : (rt_val << imm2);
      OP_SRL:   alu = (imm2 >= DW8) ? '0 : (rt_val >> imm2);
      OP_SRA:   alu = (imm2 >= DW8) ? {DATA_W{rt_val[DATA_W-1]}}
                                    : DATA_W'($signed(rt_val) >>> imm2);
      // rot==0 gives a left shift by DATA_W, which yields zero
      OP_ROR:   alu = (rt_val >> rot) | (rt_val << (DW8 - rot));
      default:  alu = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    d_read_d  = d_read_q;
    d_write_d = d_write_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    rf_we     = 1'b0;
    rf_widx   = rd_idx;
    rf_wdata  = alu;
    case (state_q)
      FETCH: begin
        if (!I_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (illegal) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (mem_op) begin
          // Request strobes and address/data are registered here so they
          // stay stable for the whole MEM_REQ/MEM_WAIT window.
          d_read_d  = is_load;
          d_write_d = !is_load;
          d_addr_d  = (op == OP_LWD || op == OP_SWD) ? rs_val : imm2_zext;
          d_wdata_d = rt_val;
          state_d   = MEM_REQ;
        end else begin
          rf_we     = alu_op;
          pc_d      = br_taken ? br_target : pc_plus4;
          instret_d = instret_q + 32'd1;
          state_d   = FETCH;
        end
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (!D_BUSYWAIT) begin
          rf_we     = d_read_q;
          rf_wdata  = D_READDATA;
          pc_d      = pc_plus4;
          instret_d = instret_q + 32'd1;
          d_read_d  = 1'b0;
          d_write_d = 1'b0;
          state_d   = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      d_read_q  <= 1'b0;
      d_write_q <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[IDX_W'(i)] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      d_read_q  <= d_read_d;
      d_write_q <= d_write_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      if (rf_we) begin
        rf_q[rf_widx] <= rf_wdata;
      end
    end
  end

  assign PC          = pc_q;
  assign D_READ      = d_read_q;
  assign D_WRITE     = d_write_q;
  assign D_ADDRESS   = d_addr_q;
  assign D_WRITEDATA = d_wdata_q;
  assign HALTED      = halted_q;
  assign INSTRET     = instret_q;

endmodule

// File: tb/tb_cpu_mc.sv
module tb_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit core
  logic        reset, i_busy, d_read, d_write, d_busy, halted;
  logic [31:0] instr, pc, instret;
  logic [7:0]  d_addr, d_wdata, d_rdata;
  logic [31:0] imem [32];

  // 16-bit core
  logic        reset16, d_read16, d_write16, halted16;
  logic [31:0] instr16, pc16, instret16;
  logic [15:0] d_addr16, d_wdata16;
  logic [31:0] imem16 [32];

  assign instr   = imem[pc[6:2]];
  assign instr16 = imem16[pc16[6:2]];

  cpu_mc #(.DATA_W(8), .NREGS(8), .PC_W(32)) u_dut (
    .CLK(clk), .RESET(reset), .INSTRUCTION(instr), .I_BUSYWAIT(i_busy),
    .PC(pc), .D_READ(d_read), .D_WRITE(d_write), .D_ADDRESS(d_addr),
    .D_WRITEDATA(d_wdata), .D_READDATA(d_rdata), .D_BUSYWAIT(d_busy),
    .HALTED(halted), .INSTRET(instret)
  );

  cpu_mc #(.DATA_W(16), .NREGS(8), .PC_W(32)) u_dut16 (
    .CLK(clk), .RESET(reset16), .INSTRUCTION(instr16), .I_BUSYWAIT(1'b0),
    .PC(pc16), .D_READ(d_read16), .D_WRITE(d_write16), .D_ADDRESS(d_addr16),
    .D_WRITEDATA(d_wdata16), .D_READDATA(16'h0000), .D_BUSYWAIT(1'b0),
    .HALTED(halted16), .INSTRET(instret16)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] ins;
    logic [7:0]  exp;
  } alu_vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] ins;
    logic [31:0] exp_pc;
  } br_vec_t;

  alu_vec_t av [24];
  br_vec_t  bv [8];

  logic [7:0] st_d [$];
  logic [7:0] st_a [$];

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic reset8();
    reset = 1'b1; i_busy = 1'b0; d_busy = 1'b0; d_rdata = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs until HALTED or the budget expires, recording each store once.
  task automatic run8(input int budget, output bit done);
    bit prev;
    prev = 1'b0;
    done = 1'b0;
    st_d.delete();
    st_a.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (d_write && !prev) begin
        st_d.push_back(d_wdata);
        st_a.push_back(d_addr);
      end
      prev = d_write;
      if (halted) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          done, found, stable, frozen;
    int          rd_cycles;
    logic [15:0] exp16_d [5];
    logic [15:0] exp16_a [5];
    logic [15:0] g16_d [$];
    logic [15:0] g16_a [$];
    bit          prev16;

    // {a, b, instruction, expected r3}
    av[0]  = '{8'h00, 8'h00, 32'h0003_0085, 8'h85};
    av[1]  = '{8'h11, 8'h3C, 32'h0103_0002, 8'h3C};
    av[2]  = '{8'h05, 8'hFE, 32'h0203_0102, 8'h03};
    av[3]  = '{8'hFF, 8'h01, 32'h0203_0102, 8'h00};
    av[4]  = '{8'h10, 8'h20, 32'h0303_0102, 8'hF0};
    av[5]  = '{8'h00, 8'h01, 32'h0303_0102, 8'hFF};
    av[6]  = '{8'hF0, 8'h3C, 32'h0403_0102, 8'h30};
    av[7]  = '{8'hF0, 8'h0C, 32'h0503_0102, 8'hFC};
    av[8]  = '{8'h13, 8'h11, 32'h0C03_0102, 8'h43};
    av[9]  = '{8'hFF, 8'hFF, 32'h0C03_0102, 8'h01};
    av[10] = '{8'h81, 8'h00, 32'h0D03_0101, 8'h02};
    av[11] = '{8'h01, 8'h00, 32'h0D03_0107, 8'h80};
    av[12] = '{8'hFF, 8'h00, 32'h0D03_0108, 8'h00};
    av[13] = '{8'h80, 8'h00, 32'h0E03_0107, 8'h01};
    av[14] = '{8'hFF, 8'h00, 32'h0E03_01C8, 8'h00};
    av[15] = '{8'h80, 8'h00, 32'h0F03_0103, 8'hF0};
    av[16] = '{8'h80, 8'h00, 32'h0F03_0108, 8'hFF};
    av[17] = '{8'h40, 8'h00, 32'h0F03_01FF, 8'h00};
    av[18] = '{8'h81, 8'h00, 32'h1003_0101, 8'hC0};
    av[19] = '{8'h81, 8'h00, 32'h1003_0109, 8'hC0};
    av[20] = '{8'h12, 8'h00, 32'h1003_0100, 8'h12};
    av[21] = '{8'h12, 8'h00, 32'h1003_0104, 8'h21};
    av[22] = '{8'h00, 8'h00, 32'h0003_007F, 8'h7F};
    av[23] = '{8'h01, 8'h02, 32'h020B_090A, 8'h03};

    // {r1, r2, control instruction at PC=8, expected next PC}
    bv[0] = '{8'h07, 8'h07, 32'h07FE_0102, 32'h0000_0004};
    bv[1] = '{8'h07, 8'h08, 32'h07FE_0102, 32'h0000_000C};
    bv[2] = '{8'h07, 8'h07, 32'h11FE_0102, 32'h0000_000C};
    bv[3] = '{8'h07, 8'h08, 32'h11FE_0102, 32'h0000_0004};
    bv[4] = '{8'h00, 8'h00, 32'h0603_0000, 32'h0000_0018};
    bv[5] = '{8'h00, 8'h00, 32'h06FD_0000, 32'h0000_0000};
    bv[6] = '{8'h00, 8'h00, 32'h0710_0102, 32'h0000_004C};
    bv[7] = '{8'h00, 8'h00, 32'h06FC_0000, 32'hFFFF_FFFC};

    reset16 = 1'b1;
    for (int i = 0; i < 32; i++) imem16[i] = 32'hFF00_0000;

    // Reset state
    clear_imem();
    reset8();
    check("reset pc", pc, 32'h0);
    check("reset instret", instret, 32'h0);
    check("reset halted", {31'b0, halted}, 32'h0);
    check("reset d_read", {31'b0, d_read}, 32'h0);
    check("reset d_write", {31'b0, d_write}, 32'h0);

    // ALU table
    for (int v = 0; v < 24; v++) begin
      clear_imem();
      imem[0] = {8'h00, 8'h01, 8'h00, av[v].a};
      imem[1] = {8'h00, 8'h02, 8'h00, av[v].b};
      imem[2] = av[v].ins;
      imem[3] = 32'h0B00_0340;
      reset8();
      run8(60, done);
      check($sformatf("alu[%0d] halt reached", v), {31'b0, done}, 32'h1);
      check($sformatf("alu[%0d] store count", v), st_d.size(), 32'd1);
      if (st_d.size() >= 1) begin
        check($sformatf("alu[%0d] result", v), st_d[0], av[v].exp);
        check($sformatf("alu[%0d] store addr", v), st_a[0], 8'h40);
      end
      check($sformatf("alu[%0d] pc at halt", v), pc, 32'h10);
      check($sformatf("alu[%0d] instret", v), instret, 32'd4);
    end

    // Control table: exactly six edges after reset
    for (int v = 0; v < 8; v++) begin
      clear_imem();
      imem[0] = {8'h00, 8'h01, 8'h00, bv[v].a};
      imem[1] = {8'h00, 8'h02, 8'h00, bv[v].b};
      imem[2] = bv[v].ins;
      reset8();
      repeat (6) @(negedge clk);
      check($sformatf("br[%0d] next pc", v), pc, bv[v].exp_pc);
      check($sformatf("br[%0d] instret", v), instret, 32'd3);
    end

    // ADD sequence with cycle-exact PC/INSTRET, then store of r3
    clear_imem();
    imem[0] = 32'h0001_0005;
    imem[1] = 32'h0002_00FE;
    imem[2] = 32'h0203_0102;
    imem[3] = 32'h0B00_0340;
    reset8();
    repeat (5) @(negedge clk);
    check("add pc after 5", pc, 32'd8);
    check("add instret after 5", instret, 32'd2);
    @(negedge clk);
    check("add pc after 6", pc, 32'd12);
    check("add instret after 6", instret, 32'd3);
    repeat (2) @(negedge clk);
    check("swi d_write in mem_req", {31'b0, d_write}, 32'h1);
    check("swi data r3", d_wdata, 8'h03);
    repeat (2) @(negedge clk);
    check("swi done pc", pc, 32'd16);
    check("swi done instret", instret, 32'd4);
    check("swi d_write cleared", {31'b0, d_write}, 32'h0);

    // Control opcodes do not write RD (IMM1=0x03 aliases r3)
    clear_imem();
    imem[0] = 32'h0001_0007;
    imem[1] = 32'h0002_0008;
    imem[2] = 32'h1103_0102;
    imem[6] = 32'h0B00_0340;
    reset8();
    run8(60, done);
    check("bne no-write store count", st_d.size(), 32'd1);
    if (st_d.size() >= 1) check("bne no-write r3", st_d[0], 8'h00);
    check("bne no-write pc", pc, 32'd28);

    // Fetch stall on I_BUSYWAIT
    clear_imem();
    imem[0] = 32'h0001_0005;
    reset8();
    i_busy = 1'b1;
    repeat (5) @(negedge clk);
    check("fetch stall pc", pc, 32'd0);
    check("fetch stall instret", instret, 32'd0);
    i_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("fetch resume pc", pc, 32'd4);

    // Load with D_BUSYWAIT high for three MEM_WAIT cycles
    clear_imem();
    imem[0] = 32'h0001_0020;
    imem[1] = 32'h0804_0001;
    imem[2] = 32'h0B00_0441;
    reset8();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (d_read) found = 1'b1;
    end
    check("lwd read seen", {31'b0, found}, 32'h1);
    check("lwd address", d_addr, 8'h20);
    rd_cycles = 0;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!d_read) break;
      if (d_addr !== 8'h20) stable = 1'b0;
      rd_cycles++;
      d_busy  = (rd_cycles <= 4);
      d_rdata = d_busy ? 8'h5A : 8'hA5;
      @(negedge clk);
    end
    d_busy = 1'b0;
    check("lwd d_read cycles", rd_cycles, 32'd5);
    check("lwd address stable", {31'b0, stable}, 32'h1);
    check("lwd pc", pc, 32'd8);
    check("lwd instret", instret, 32'd2);
    run8(40, done);
    check("lwd store count", st_d.size(), 32'd1);
    if (st_d.size() >= 1) check("lwd r4 value", st_d[0], 8'hA5);

    // Reset while a store sits in MEM_WAIT
    clear_imem();
    imem[0] = 32'h0001_0003;
    imem[1] = 32'h0B00_0140;
    reset8();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (d_write) found = 1'b1;
    end
    check("swi write seen", {31'b0, found}, 32'h1);
    d_busy = 1'b1;
    @(negedge clk);
    check("swi held in mem_wait", {31'b0, d_write}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    d_busy = 1'b0;
    check("rst store d_write", {31'b0, d_write}, 32'h0);
    check("rst store pc", pc, 32'h0);
    check("rst store instret", instret, 32'h0);
    repeat (2) @(negedge clk);
    check("rst restart pc", pc, 32'd4);
    check("rst restart instret", instret, 32'd1);

    // Illegal opcode
    clear_imem();
    imem[0] = 32'h0001_0001;
    imem[1] = 32'h2A00_0000;
    reset8();
    repeat (3) @(negedge clk);
    check("pre-halt halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    check("halted set", {31'b0, halted}, 32'h1);
    check("halt pc", pc, 32'd4);
    check("halt instret", instret, 32'd1);
    frozen = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pc !== 32'd4 || !halted || d_read || d_write || instret !== 32'd1) frozen = 1'b0;
    end
    check("halt frozen 20 cycles", {31'b0, frozen}, 32'h1);
    reset8();
    check("halt cleared by reset", {31'b0, halted}, 32'h0);

    // DATA_W=16 shifts
    imem16[0]  = 32'h0001_0080;
    imem16[1]  = 32'h0B00_013F;
    imem16[2]  = 32'h0D01_0108;
    imem16[3]  = 32'h0F03_0114;
    imem16[4]  = 32'h0B00_0340;
    imem16[5]  = 32'h0E04_0114;
    imem16[6]  = 32'h0B00_0441;
    imem16[7]  = 32'h1005_0114;
    imem16[8]  = 32'h0B00_0542;
    imem16[9]  = 32'h0F06_010F;
    imem16[10] = 32'h0B00_0643;
    exp16_d = '{16'hFF80, 16'hFFFF, 16'h0000, 16'h0800, 16'hFFFF};
    exp16_a = '{16'h003F, 16'h0040, 16'h0041, 16'h0042, 16'h0043};
    reset16 = 1'b1;
    @(negedge clk);
    reset16 = 1'b0;
    prev16 = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (d_write16 && !prev16) begin
        g16_d.push_back(d_wdata16);
        g16_a.push_back(d_addr16);
      end
      prev16 = d_write16;
      if (halted16) begin
        done = 1'b1;
        break;
      end
    end
    check("w16 halt reached", {31'b0, done}, 32'h1);
    check("w16 store count", g16_d.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < g16_d.size()) begin
        check($sformatf("w16 store[%0d] data", i), g16_d[i], exp16_d[i]);
        check($sformatf("w16 store[%0d] addr", i), g16_a[i], exp16_a[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
